// File: rtl/pio_input_conditioner.sv
// ---------------------------------------------------------------------------
// pio_input_conditioner
//
// Fabric-side front end for the HPS PIO and reset-request inputs. Raw board
// push-buttons and DIP switches are synchronised, then debounced. The clean
// levels feed the button/dipsw PIO exports. Every accepted level change
// produces a one-cycle pulse on the STM hardware-event bus. A long press on
// button 0 produces a timed, active-low warm-reset request into the HPS.
//
// Ports:
//   clk_clk              - system clock
//   reset_reset          - asynchronous, active-high reset of all state
//   button_raw           - raw push-buttons, 0 = pressed
//   dipsw_raw            - raw DIP switches
//   button_export        - debounced buttons (1 = released)
//   dipsw_export         - debounced switches
//   stm_hwevents         - [NUM_SWITCHES-1:0] switch changes,
//                          [NUM_SWITCHES+NUM_BUTTONS-1:NUM_SWITCHES] button
//                          changes, [27] long press, all other bits 0
//   f2h_warm_reset_req_n - active-low warm-reset request to the HPS
//
// Parameter limits: DEBOUNCE_CYCLES, LONG_PRESS_CYCLES and RESET_PULSE_CYCLES
// must be >= 1, and NUM_SWITCHES + NUM_BUTTONS must be <= 27.
// ---------------------------------------------------------------------------
module pio_input_conditioner #(
    parameter int NUM_BUTTONS        = 2,
    parameter int NUM_SWITCHES       = 4,
    parameter int DEBOUNCE_CYCLES    = 500000,
    parameter int LONG_PRESS_CYCLES  = 150000000,
    parameter int RESET_PULSE_CYCLES = 16
) (
    input  logic                    clk_clk,
    input  logic                    reset_reset,
    input  logic [NUM_BUTTONS-1:0]  button_raw,
    input  logic [NUM_SWITCHES-1:0] dipsw_raw,
    output logic [NUM_BUTTONS-1:0]  button_export,
    output logic [NUM_SWITCHES-1:0] dipsw_export,
    output logic [27:0]             stm_hwevents,
    output logic                    f2h_warm_reset_req_n
);

    // Buttons and switches are handled as one vector whose bit order matches
    // the low part of the event bus: switches at the bottom, buttons above.
    localparam int NUM_INPUTS = NUM_BUTTONS + NUM_SWITCHES;
    localparam int DB_W       = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int LP_MAX     = (LONG_PRESS_CYCLES > RESET_PULSE_CYCLES) ?
                                LONG_PRESS_CYCLES : RESET_PULSE_CYCLES;
    localparam int LP_W       = $clog2(LP_MAX + 1);
    localparam int BTN0_IDX   = NUM_SWITCHES;

    // Idle level of every input: buttons released (1), switches off (0).
    localparam logic [NUM_INPUTS-1:0] RESET_LEVELS =
        {{NUM_BUTTONS{1'b1}}, {NUM_SWITCHES{1'b0}}};

    localparam logic [DB_W-1:0] DB_LAST    = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [LP_W-1:0] LP_LAST    = LP_W'(LONG_PRESS_CYCLES - 1);
    localparam logic [LP_W-1:0] PULSE_LAST = LP_W'(RESET_PULSE_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_HELD,
        ST_REQ,
        ST_WAIT_REL
    } lp_state_t;

    logic [NUM_INPUTS-1:0]            raw_all;
    logic [NUM_INPUTS-1:0]            sync1_q, sync1_d;
    logic [NUM_INPUTS-1:0]            sync2_q, sync2_d;
    logic [NUM_INPUTS-1:0]            stable_q, stable_d;
    logic [NUM_INPUTS-1:0]            evt_q, evt_d;
    logic [NUM_INPUTS-1:0][DB_W-1:0]  db_cnt_q, db_cnt_d;

    lp_state_t                        lp_state_q, lp_state_d;
    logic [LP_W-1:0]                  lp_cnt_q, lp_cnt_d;
    logic                             lp_evt_q, lp_evt_d;
    logic                             req_n_q, req_n_d;
    logic                             btn0_pressed;

    assign raw_all = {button_raw, dipsw_raw};

    // Two-flop synchroniser stages.
    always_comb begin
        sync1_d = raw_all;
        sync2_d = sync1_q;
    end

    // Per-bit debounce: the counter only runs while the synchronised level
    // disagrees with the accepted level. Any return to agreement clears it,
    // so a level is accepted only after DEBOUNCE_CYCLES unbroken cycles.
    always_comb begin
        stable_d = stable_q;
        evt_d    = '0;
        db_cnt_d = '0;
        for (int i = 0; i < NUM_INPUTS; i++) begin
            if (sync2_q[i] != stable_q[i]) begin
                if (db_cnt_q[i] == DB_LAST) begin
                    stable_d[i] = sync2_q[i];
                    evt_d[i]    = 1'b1;
                end else begin
                    db_cnt_d[i] = db_cnt_q[i] + DB_W'(1);
                end
            end
        end
    end

    assign btn0_pressed = ~stable_q[BTN0_IDX];

    // Long-press FSM on debounced button 0. One counter serves both the hold
    // time in HELD and the pulse width in REQ. WAIT_REL blocks a second
    // request until the button has been let go.
    always_comb begin
        lp_state_d = lp_state_q;
        lp_cnt_d   = '0;
        lp_evt_d   = 1'b0;
        case (lp_state_q)
            ST_IDLE: begin
                if (btn0_pressed) begin
                    lp_state_d = ST_HELD;
                end
            end
            ST_HELD: begin
                if (!btn0_pressed) begin
                    lp_state_d = ST_IDLE;
                end else if (lp_cnt_q == LP_LAST) begin
                    lp_state_d = ST_REQ;
                    lp_evt_d   = 1'b1;
                end else begin
                    lp_cnt_d = lp_cnt_q + LP_W'(1);
                end
            end
            ST_REQ: begin
                // The button level is ignored here so that the pulse always
                // has its full width.
                if (lp_cnt_q == PULSE_LAST) begin
                    lp_state_d = ST_WAIT_REL;
                end else begin
                    lp_cnt_d = lp_cnt_q + LP_W'(1);
                end
            end
            ST_WAIT_REL: begin
                if (!btn0_pressed) begin
                    lp_state_d = ST_IDLE;
                end
            end
            default: begin
                lp_state_d = ST_IDLE;
            end
        endcase
        // The request comes from a flop, so it is low for exactly the cycles
        // spent in REQ.
        req_n_d = (lp_state_d != ST_REQ);
    end

    always_ff @(posedge clk_clk or posedge reset_reset) begin
        if (reset_reset) begin
            sync1_q    <= RESET_LEVELS;
            sync2_q    <= RESET_LEVELS;
            stable_q   <= RESET_LEVELS;
            evt_q      <= '0;
            db_cnt_q   <= '0;
            lp_state_q <= ST_IDLE;
            lp_cnt_q   <= '0;
            lp_evt_q   <= 1'b0;
            req_n_q    <= 1'b1;
        end else begin
            sync1_q    <= sync1_d;
            sync2_q    <= sync2_d;
            stable_q   <= stable_d;
            evt_q      <= evt_d;
            db_cnt_q   <= db_cnt_d;
            lp_state_q <= lp_state_d;
            lp_cnt_q   <= lp_cnt_d;
            lp_evt_q   <= lp_evt_d;
            req_n_q    <= req_n_d;
        end
    end

    assign button_export        = stable_q[NUM_INPUTS-1:NUM_SWITCHES];
    assign dipsw_export         = stable_q[NUM_SWITCHES-1:0];
    assign f2h_warm_reset_req_n = req_n_q;

    // Event bus assembly: change pulses at the bottom, long press on bit 27.
    always_comb begin
        stm_hwevents                 = '0;
        stm_hwevents[NUM_INPUTS-1:0] = evt_q;
        stm_hwevents[27]             = lp_evt_q;
    end

endmodule
